switch_top: RTL and testbench
=============================

SWITCH_TOP -- requirements
Module: switch_top

Interface
REQ-001 Parameters (declaration order): DATA_W, default 8, element width in bits; ROWS, default 4, input matrix rows; COLS, default 4, input matrix columns.
REQ-002 Port order: clk, rst, ctrl, input_matrix, output_matrix, in_val, out_val.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ctrl  input  1  mode select: 1 = transpose, 0 = pass-through.
REQ-006 input_matrix  input  unpacked [0:ROWS-1][0:COLS-1] of DATA_W  source matrix.
REQ-007 output_matrix  output  unpacked [0:COLS-1][0:ROWS-1] of DATA_W  result matrix.
REQ-008 in_val  input  1  input_matrix and ctrl are valid this cycle.
REQ-009 out_val  output  1  output_matrix holds a valid result.

Function
REQ-010 Transpose mode (ctrl=1): output_matrix[i][j] SHALL equal captured input[j][i] for all i, j.
REQ-011 Pass-through mode (ctrl=0): output_matrix[i][j] SHALL equal captured input[i][j]; this mode is legal only when ROWS==COLS.
REQ-012 Stage 1: on a clock edge with in_val=1, input_matrix SHALL be registered into input_elements and ctrl into a mode register; with in_val=0 both hold their values.
REQ-013 Stage 2: the switch mesh SHALL be combinational from input_elements and the mode register; its result is registered into output_elements every cycle.
REQ-014 output_matrix SHALL be driven directly from output_elements.
REQ-015 Latency SHALL be exactly 2 cycles: out_val(t) = in_val(t-2), with no gaps.
REQ-016 Throughput SHALL be one matrix per cycle; back-to-back in_val SHALL yield back-to-back results in order.
REQ-017 A ctrl change takes effect only for matrices captured with in_val=1.
REQ-018 A new in_val arriving while an earlier result is still in flight SHALL NOT corrupt that earlier result.
REQ-019 Mesh: cell (i,j) SHALL receive in_elements_down[0:ROWS-1] (column j of input_elements) and in_elements_across[0:COLS-1] (row i of input_elements).
REQ-020 Each cell SHALL drive out_elements[0:ROWS-1]: its across or down selection according to the mode.
REQ-021 Each cell's generate scope SHALL expose in_e_down and out_elements copies of the cell's ports.
REQ-022 outputs[k][i][j] SHALL hold the partial matrix contributed by mesh row k; output_elements is the row-k merge of outputs.

Reset
REQ-023 With rst=1 at a clock edge, input_elements, output_elements, the mode register and the out_val pipeline SHALL all clear to 0.
REQ-024 Reset overrides in_val; data in flight is discarded.
REQ-025 out_val SHALL stay 0 for 2 cycles after rst deasserts, unless in_val is asserted during that time.

Structure
REQ-026 A shared package SHALL hold the default DATA_W, ROWS and COLS values and the element typedef (logic [DATA_W-1:0]).
REQ-027 The mesh SHALL be built with nested generate loops named g_in_i (rows) and g_in_j (columns).
REQ-028 Each loop iteration SHALL contain one instance, named ss, of the sub-module switch_cell.
REQ-029 switch_cell ports: ctrl, in_elements_down, in_elements_across, out_elements; the cell is purely combinational.
REQ-030 Hierarchical names input_elements, output_elements and outputs SHALL exist for debug.

Verification
REQ-031 Reset: rst=1 for 1 cycle -> output_matrix all 0x00 and out_val=0.
REQ-032 Transpose: input[i][j]=0x10*i+0x0A+j, ctrl=1, in_val=1 -> after 2 cycles out_val=1 and output[0][1]=0x1A, output[3][0]=0x0D, output[2][2]=0x2C (full matrix checked).
REQ-033 Pass-through: same input, ctrl=0 -> output[0][1]=0x0B, output[3][0]=0x3A.
REQ-034 Back-to-back: alternate transpose and pass-through over 4 consecutive cycles -> 4 correct results in order on consecutive cycles, out_val continuous.
REQ-035 Hold: in_val=0 after one capture, input_matrix changed -> output_matrix unchanged; out_val falls 2 cycles after in_val falls.
REQ-036 Mid-reset: rst asserted 1 cycle after in_val -> outputs 0x00 and out_val=0 on the next edge.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared defaults and element type for the matrix switch.
// No ports; imported by switch_cell and switch_top.
package switch_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ROWS   = 4;
  localparam int unsigned DEF_COLS   = 4;

  typedef logic [DEF_DATA_W-1:0] elem_t;

endpackage : switch_pkg

// File: rtl/switch_cell.sv
// Combinational mesh cell: forwards either its down (column) or across (row)
// vector, depending on the mode.
// Ports:
//   ctrl               1 = transpose (select down), 0 = pass-through (select across)
//   in_elements_down   column of the captured matrix, ROWS elements
//   in_elements_across row of the captured matrix, COLS elements
//   out_elements       selected vector, ROWS elements
module switch_cell
  import switch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS
) (
  input  logic              ctrl,
  input  logic [DATA_W-1:0] in_elements_down   [0:ROWS-1],
  input  logic [DATA_W-1:0] in_elements_across [0:COLS-1],
  output logic [DATA_W-1:0] out_elements       [0:ROWS-1]
);

  // Across entries past COLS do not exist; pass-through is only legal for
  // square matrices, so those slots read as zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_sel
    if (r < COLS) begin : g_both
      assign out_elements[r] = ctrl ? in_elements_down[r] : in_elements_across[r];
    end else begin : g_down_only
      assign out_elements[r] = ctrl ? in_elements_down[r] : '0;
    end
  end

endmodule : switch_cell

// File: rtl/switch_top.sv
// Two-stage matrix switch: transposes (ctrl=1) or passes through (ctrl=0)
// a ROWS x COLS matrix, one matrix per cycle, latency 2.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ctrl           mode for the matrix presented with in_val
//   input_matrix   source matrix [ROWS][COLS]
//   output_matrix  registered result [COLS][ROWS]
//   in_val         input_matrix/ctrl valid this cycle
//   out_val        output_matrix valid
module switch_top
  import switch_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl,
  input  logic [DATA_W-1:0] input_matrix  [0:ROWS-1][0:COLS-1],
  output logic [DATA_W-1:0] output_matrix [0:COLS-1][0:ROWS-1],
  input  logic              in_val,
  output logic              out_val
);

  logic [DATA_W-1:0] input_elements    [0:ROWS-1][0:COLS-1];
  logic              mode_q;
  logic [DATA_W-1:0] outputs           [0:ROWS-1][0:COLS-1][0:ROWS-1];
  logic [DATA_W-1:0] output_elements_d [0:COLS-1][0:ROWS-1];
  logic [DATA_W-1:0] output_elements   [0:COLS-1][0:ROWS-1];
  logic [1:0]        val_q;

  // Stage 1: capture matrix and mode only on valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      input_elements <= '{default: '0};
      mode_q         <= 1'b0;
    end else if (in_val) begin
      input_elements <= input_matrix;
      mode_q         <= ctrl;
    end
  end

  // Switch mesh. Cell (i,j) sees column j and row i and produces output row j
  // (transpose) or row i (pass-through). Only one cell per output row is let
  // through into outputs[i] so the merge below is a plain OR.
  for (genvar i = 0; i < ROWS; i++) begin : g_in_i
    for (genvar j = 0; j < COLS; j++) begin : g_in_j
      logic [DATA_W-1:0] in_e_down    [0:ROWS-1];
      logic [DATA_W-1:0] in_e_across  [0:COLS-1];
      logic [DATA_W-1:0] out_elements [0:ROWS-1];

      for (genvar k = 0; k < ROWS; k++) begin : g_down
        assign in_e_down[k] = input_elements[k][j];
      end
      for (genvar k = 0; k < COLS; k++) begin : g_across
        assign in_e_across[k] = input_elements[i][k];
      end

      switch_cell #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS),
        .COLS   (COLS)
      ) ss (
        .ctrl               (mode_q),
        .in_elements_down   (in_e_down),
        .in_elements_across (in_e_across),
        .out_elements       (out_elements)
      );

      // Transpose: mesh row 0 supplies every output row j.
      // Pass-through: mesh row i supplies output row i via the diagonal cell.
      for (genvar r = 0; r < ROWS; r++) begin : g_part
        assign outputs[i][j][r] = (mode_q ? (i == 0) : (i == j)) ? out_elements[r] : '0;
      end
    end
  end

  // Merge the per-mesh-row partial matrices.
  always_comb begin
    for (int a = 0; a < COLS; a++) begin
      for (int b = 0; b < ROWS; b++) begin
        output_elements_d[a][b] = '0;
        for (int k = 0; k < ROWS; k++) begin
          output_elements_d[a][b] = output_elements_d[a][b] | outputs[k][a][b];
        end
      end
    end
  end

  // Stage 2: result register (every cycle) and valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_elements <= '{default: '0};
      val_q           <= 2'b00;
    end else begin
      output_elements <= output_elements_d;
      val_q           <= {val_q[0], in_val};
    end
  end

  assign output_matrix = output_elements;
  assign out_val       = val_q[1];

endmodule : switch_top

// File: tb/tb_switch_top.sv
// Directed, table-driven bench for switch_top (4x4, 8-bit).
// Each table row is applied before one rising edge; its expectations describe
// the outputs just after that edge.
module tb_switch_top;

  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int NVEC = 18;

  typedef enum int { K_ZERO, K_TR, K_PT } kind_e;

  typedef struct {
    logic       rst;
    logic       ctrl;
    logic       in_val;
    logic [7:0] base;
    logic       exp_val;
    kind_e      kind;
    logic [7:0] exp_base;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl;
  logic          in_val;
  logic          out_val;
  logic [DW-1:0] in_m  [0:R-1][0:C-1];
  logic [DW-1:0] out_m [0:C-1][0:R-1];

  vec_t vecs [NVEC];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  switch_top #(
    .DATA_W (DW),
    .ROWS   (R),
    .COLS   (C)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl          (ctrl),
    .input_matrix  (in_m),
    .output_matrix (out_m),
    .in_val        (in_val),
    .out_val       (out_val)
  );

  // Source pattern: element [r][c] = base + 0x10*r + c.
  function automatic logic [7:0] pat(input logic [7:0] base, input int r, input int c);
    return base + 8'(16 * r + c);
  endfunction

  function automatic logic [7:0] exp_el(input kind_e k, input logic [7:0] b, input int i, input int j);
    case (k)
      K_TR:    return pat(b, j, i);
      K_PT:    return pat(b, i, j);
      default: return 8'h00;
    endcase
  endfunction

  function automatic vec_t mk(input logic rs, input logic ct, input logic iv, input logic [7:0] bs,
                              input logic ev, input kind_e kd, input logic [7:0] eb);
    vec_t v;
    v.rst = rs; v.ctrl = ct; v.in_val = iv; v.base = bs;
    v.exp_val = ev; v.kind = kd; v.exp_base = eb;
    return v;
  endfunction

  task automatic drive(input int n);
    rst    = vecs[n].rst;
    ctrl   = vecs[n].ctrl;
    in_val = vecs[n].in_val;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        in_m[r][c] = pat(vecs[n].base, r, c);
  endtask

  task automatic spot(input int n, input int i, input int j, input logic [7:0] want);
    n_chk++;
    if (out_m[i][j] !== want) begin
      n_fail++;
      $display("FAIL spot row%0d out[%0d][%0d]: got %02h want %02h", n, i, j, out_m[i][j], want);
    end
  endtask

  task automatic check(input int n);
    int bad_i, bad_j;
    logic bad;
    n_chk++;
    if (out_val !== vecs[n].exp_val) begin
      n_fail++;
      $display("FAIL out_val row%0d: got %0b want %0b", n, out_val, vecs[n].exp_val);
    end
    bad = 1'b0; bad_i = 0; bad_j = 0;
    for (int i = 0; i < C; i++)
      for (int j = 0; j < R; j++)
        if (!bad && out_m[i][j] !== exp_el(vecs[n].kind, vecs[n].exp_base, i, j)) begin
          bad = 1'b1; bad_i = i; bad_j = j;
        end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL matrix row%0d out[%0d][%0d]: got %02h want %02h", n, bad_i, bad_j,
               out_m[bad_i][bad_j], exp_el(vecs[n].kind, vecs[n].exp_base, bad_i, bad_j));
    end
    // Hand-computed corner values for the reference pattern (base 0x0A).
    if (n == 2) begin
      spot(n, 0, 1, 8'h1A);
      spot(n, 3, 0, 8'h0D);
      spot(n, 2, 2, 8'h2C);
    end
    if (n == 5) begin
      spot(n, 0, 1, 8'h0B);
      spot(n, 3, 0, 8'h3A);
    end
  endtask

  initial begin
    //            rst   ctrl  inval base   exp_val kind    exp_base
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, K_ZERO, 8'h00); // reset
    vecs[1]  = mk(1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, K_ZERO, 8'h00); // capture transpose
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 8'h55, 1'b1, K_TR,   8'h0A); // result, input changed
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 8'h66, 1'b0, K_TR,   8'h0A); // hold, ctrl ignored
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, K_TR,   8'h0A); // capture pass-through
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 8'h77, 1'b1, K_PT,   8'h0A);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, K_PT,   8'h0A); // back-to-back x4
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'h21, 1'b1, K_TR,   8'h00);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 8'h42, 1'b1, K_PT,   8'h21);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h63, 1'b1, K_TR,   8'h42);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 8'h99, 1'b1, K_PT,   8'h63);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 8'h88, 1'b0, K_PT,   8'h63); // out_val falls
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, K_PT,   8'h63); // capture then...
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, K_ZERO, 8'h00); // ...mid-flight reset
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 8'h44, 1'b0, K_ZERO, 8'h00);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 8'h45, 1'b0, K_ZERO, 8'h00);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, K_ZERO, 8'h00); // recovery capture
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, K_TR,   8'h33);

    rst = 1'b1; ctrl = 1'b0; in_val = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        in_m[r][c] = '0;

    for (int n = 0; n < NVEC; n++) begin
      @(negedge clk);
      if (n > 0) check(n - 1);
      drive(n);
    end
    @(negedge clk);
    check(NVEC - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_switch_top
